// File: rtl/pio_gpio_ext.sv
// pio_gpio_ext: Avalon-MM GPIO slave with per-bit direction, atomic set/clear and a two-flop input synchroniser.
// Define PIO_GPIO_EXT_EDGE_IRQ_EN to build edge capture, the IRQMASK/EDGECAP registers and irq.
module pio_gpio_ext #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int unsigned      EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    // EDGE_TYPE: 0 rising, 1 falling, anything else both edges.
    function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] prev);
        case (EDGE_TYPE)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    logic             wr;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] dir_d;
    logic [WIDTH-1:0] in_meta_q;
    logic [WIDTH-1:0] in_sync_q;
    logic [WIDTH-1:0] pin_view;

    assign wr       = chipselect & ~write_n;
    assign pin_view = (dir_q & data_out_q) | (~dir_q & in_sync_q);

    always_comb begin
        data_out_d = data_out_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_out_d = writedata;
                ADDR_OUTSET: data_out_d = data_out_q | writedata;
                ADDR_OUTCLR: data_out_d = data_out_q & ~writedata;
                default:     data_out_d = data_out_q;
            endcase
        end
    end

    always_comb begin
        dir_d = dir_q;
        if (wr && address == ADDR_DIR) begin
            dir_d = writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= DIR_RESET;
            in_meta_q  <= '0;
            in_sync_q  <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            in_meta_q  <= in_port;
            in_sync_q  <= in_meta_q;
        end
    end

    assign out_port = data_out_q;
    assign oe       = dir_q;

`ifdef PIO_GPIO_EXT_EDGE_IRQ_EN
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;

    logic [WIDTH-1:0] in_prev_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;

    // A fresh edge overrides a write-1-to-clear landing on the same bit.
    assign edge_det  = edge_detect(in_sync_q, in_prev_q);
    assign cap_clr   = (wr && address == ADDR_EDGECAP) ? writedata : '0;
    assign edgecap_d = edge_det | (edgecap_q & ~cap_clr);
    assign irqmask_d = (wr && address == ADDR_IRQMASK) ? writedata : irqmask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev_q <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            in_prev_q <= in_sync_q;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = pin_view;
            ADDR_DIR:     readdata = dir_q;
`ifdef PIO_GPIO_EXT_EDGE_IRQ_EN
            ADDR_IRQMASK: readdata = irqmask_q;
            ADDR_EDGECAP: readdata = edgecap_q;
`endif
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pio_gpio_ext.sv
// Directed bench for pio_gpio_ext (WIDTH=8, RESET_VALUE=8'h01, DIR_RESET=8'hFF, rising-edge capture).
module tb_pio_gpio_ext;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b1;
    logic [2:0] address    = 3'd0;
    logic       chipselect = 1'b0;
    logic       write_n    = 1'b1;
    logic [7:0] writedata  = 8'h00;
    logic [7:0] in_port    = 8'h00;
    logic [7:0] readdata;
    logic [7:0] out_port;
    logic [7:0] oe;
    logic       irq;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pio_gpio_ext #(
        .WIDTH      (8),
        .RESET_VALUE(8'h01),
        .DIR_RESET  (8'hFF),
        .EDGE_TYPE  (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%02h, expected 'h%02h", tag, obs, exp);
        end
    endtask

    task automatic check_read(input string tag, input logic [2:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, checked before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst_out_port", out_port, 8'h01);
        check("rst_oe", oe, 8'hFF);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check_read("rst_edgecap", 3'd3, 8'h00);
        check_read("rst_data", 3'd0, 8'h01);
        tick();
        check_read("rst_dir", 3'd1, 8'hFF);
        tick();
        reset_n = 1'b1;
        tick();

        // Load, set and clear of the output register.
        bus_write(3'd0, 8'hF0);
        check("wr_data", out_port, 8'hF0);
        bus_write(3'd4, 8'h05);
        check("outset", out_port, 8'hF5);
        bus_write(3'd5, 8'h30);
        check("outclr", out_port, 8'hC5);
        check_read("rd_outset", 3'd4, 8'h00);
        check_read("rd_outclr", 3'd5, 8'h00);
        bus_write(3'd6, 8'hFF);
        check("reserved_wr", out_port, 8'hC5);
        check_read("rd_reserved", 3'd6, 8'h00);
        check_read("rd_data_out", 3'd0, 8'hC5);

        // Mixed direction readback and synchroniser latency.
        bus_write(3'd1, 8'h0F);
        check("wr_dir", oe, 8'h0F);
        bus_write(3'd0, 8'hAA);
        check("wr_data_aa", out_port, 8'hAA);
        in_port = 8'h5C;
        check_read("mix_0clk", 3'd0, 8'h0A);
        tick();
        check_read("mix_1clk", 3'd0, 8'h0A);
        tick();
        check_read("mix_2clk", 3'd0, 8'h5A);

`ifdef PIO_GPIO_EXT_EDGE_IRQ_EN
        tick();
        check_read("cap_5c", 3'd3, 8'h5C);
        check("cap_5c_irq", {7'b0, irq}, 8'h00);
        in_port = 8'h00;
        tick();
        tick();
        tick();
        bus_write(3'd3, 8'hFF);
        check_read("cap_cleared", 3'd3, 8'h00);
        bus_write(3'd2, 8'h04);
        check_read("rd_irqmask", 3'd2, 8'h04);

        // Rising edge on bit 2: exactly 3 clk to capture.
        in_port = 8'h04;
        tick();
        check_read("edge_1clk", 3'd3, 8'h00);
        check("edge_1clk_irq", {7'b0, irq}, 8'h00);
        tick();
        check_read("edge_2clk", 3'd3, 8'h00);
        check("edge_2clk_irq", {7'b0, irq}, 8'h00);
        tick();
        check_read("edge_3clk", 3'd3, 8'h04);
        check("edge_3clk_irq", {7'b0, irq}, 8'h01);
        bus_write(3'd3, 8'h04);
        check_read("w1c", 3'd3, 8'h00);
        check("w1c_irq", {7'b0, irq}, 8'h00);

        // New edge lands on the same edge as a clear of the same bit.
        in_port = 8'h00;
        tick();
        tick();
        tick();
        in_port = 8'h04;
        tick();
        tick();
        bus_write(3'd3, 8'h04);
        check_read("set_wins", 3'd3, 8'h04);
        check("set_wins_irq", {7'b0, irq}, 8'h01);
        tick();
        check_read("cap_hold", 3'd3, 8'h04);
        check("pre_reset_irq", {7'b0, irq}, 8'h01);
`else
        bus_write(3'd2, 8'hFF);
        check_read("noirq_rd2", 3'd2, 8'h00);
        bus_write(3'd3, 8'hFF);
        check_read("noirq_rd3", 3'd3, 8'h00);
        in_port = 8'hFF;
        tick();
        tick();
        tick();
        tick();
        check("noirq_irq", {7'b0, irq}, 8'h00);
        check_read("noirq_rd3_after", 3'd3, 8'h00);
`endif

        // Asynchronous reset in the middle of a write.
        address    = 3'd0;
        writedata  = 8'hFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_irq", {7'b0, irq}, 8'h00);
        check("arst_out_port", out_port, 8'h01);
        check("arst_oe", oe, 8'hFF);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_read("arst_edgecap", 3'd3, 8'h00);
        check_read("arst_irqmask", 3'd2, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        check_read("post_rst_data", 3'd0, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
